// File: rtl/fsm_seq_sched.sv
// Two-source round-robin scheduler feeding one serial sequence detector; W-bit words go in MSB-first, per-bit hits come back as mask/count.
// Latency: transfer at edge 0 -> m_valid in cycle W+DET_LAT+1 (one cycle more with FSM_SEQ_SCHED_CLR_EN, which adds a detector-clear state).
// Backpressure: a result is held in DONE until m_ready; no source is granted until the result has been accepted.
module fsm_seq_sched #(
    parameter int W       = 8,
    parameter int DET_LAT = 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     s0_valid,
    input  logic [W-1:0]             s0_data,
    output logic                     s0_ready,
    input  logic                     s1_valid,
    input  logic [W-1:0]             s1_data,
    output logic                     s1_ready,
    output logic                     det_en,
    output logic                     det_in,
    output logic                     det_clr,
    input  logic                     det_out,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_id,
    output logic [W-1:0]             m_mask,
    output logic [$clog2(W+1)-1:0]   m_count
);

    localparam int CW      = $clog2(W + 1);
    localparam int CNT_MAX = (W > DET_LAT) ? W : DET_LAT;
    localparam int TW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [TW-1:0]      cnt;
    logic [W-1:0]       sreg;
    logic               last;      // source served most recently
    logic [DET_LAT-1:0] vpipe;     // marks detector responses that belong to SHIFT bits
    logic               gnt0;
    logic               gnt1;
    logic               xfer;
    logic               xfer_id;

    // Round-robin grant: a lone requester wins, a tie goes to the source not served last.
    always_comb begin
        gnt0     = s0_valid && (!s1_valid || last);
        gnt1     = s1_valid && (!s0_valid || !last);
        s0_ready = (state == IDLE) && gnt0;
        s1_ready = (state == IDLE) && gnt1;
        xfer     = (s0_valid && s0_ready) || (s1_valid && s1_ready);
        xfer_id  = s1_valid && s1_ready;
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and detector/result strobes.
    always_comb begin
        state_nxt = state;
        det_en    = 1'b0;
        det_in    = 1'b0;
        m_valid   = 1'b0;
`ifdef FSM_SEQ_SCHED_CLR_EN
        det_clr   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (xfer) begin
`ifdef FSM_SEQ_SCHED_CLR_EN
                    state_nxt = CLR;
`else
                    state_nxt = SHIFT;
`endif
                end
            end
`ifdef FSM_SEQ_SCHED_CLR_EN
            CLR: begin
                det_clr   = 1'b1;
                state_nxt = SHIFT;
            end
`endif
            SHIFT: begin
                det_en = 1'b1;
                det_in = sreg[W-1];
                if (cnt == '0) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                det_en = 1'b1;
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifndef FSM_SEQ_SCHED_CLR_EN
    // Without the clear state the detector runs as one continuous stream.
    assign det_clr = 1'b0;
`endif

    // Datapath: word latch, bit/drain counter, response tagging and hit accumulation.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sreg    <= '0;
            cnt     <= '0;
            last    <= 1'b1;
            m_id    <= 1'b0;
            m_mask  <= '0;
            m_count <= '0;
            vpipe   <= '0;
        end else begin
            // Only bits driven in SHIFT are tagged; drain responses fall off the end.
            for (int i = DET_LAT - 1; i > 0; i--) begin
                vpipe[i] <= vpipe[i-1];
            end
            vpipe[0] <= (state == SHIFT);

            if (vpipe[DET_LAT-1]) begin
                m_mask  <= {m_mask[W-2:0], det_out};
                m_count <= m_count + CW'(det_out);
            end

            case (state)
                IDLE: begin
                    if (xfer) begin
                        sreg    <= xfer_id ? s1_data : s0_data;
                        m_id    <= xfer_id;
                        last    <= xfer_id;
                        m_mask  <= '0;
                        m_count <= '0;
                        cnt     <= TW'(W - 1);
                        vpipe   <= '0;
                    end
                end
                SHIFT: begin
                    sreg <= sreg << 1;
                    if (cnt == '0) begin
                        cnt <= TW'(DET_LAT - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_seq_sched.sv
// Scoreboard bench for fsm_seq_sched with an echo detector (det_out = det_in registered when det_en).
// Latency: expects m_valid 10 cycles after accept (11 with FSM_SEQ_SCHED_CLR_EN).
// Backpressure: exercises m_ready stall in DONE and reset mid-word.
module tb_fsm_seq_sched;

    localparam int W       = 8;
    localparam int DET_LAT = 1;
`ifdef FSM_SEQ_SCHED_CLR_EN
    localparam int OFF = 1;
`else
    localparam int OFF = 0;
`endif

    typedef struct packed {
        logic       id;
        logic [7:0] mask;
        logic [3:0] cnt;
    } res_t;

    logic       sys_clk;
    logic       sys_rst;
    logic       s0_valid, s1_valid;
    logic [7:0] s0_data, s1_data;
    logic       s0_ready, s1_ready;
    logic       det_en, det_in, det_clr, det_out;
    logic       m_valid, m_ready, m_id;
    logic [7:0] m_mask;
    logic [3:0] m_count;

    res_t q[$];
    int   n_cmp;
    int   n_err;

    fsm_seq_sched #(.W(W), .DET_LAT(DET_LAT)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .s0_valid (s0_valid),
        .s0_data  (s0_data),
        .s0_ready (s0_ready),
        .s1_valid (s1_valid),
        .s1_data  (s1_data),
        .s1_ready (s1_ready),
        .det_en   (det_en),
        .det_in   (det_in),
        .det_clr  (det_clr),
        .det_out  (det_out),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_id     (m_id),
        .m_mask   (m_mask),
        .m_count  (m_count)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Echo detector, one cycle of latency.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            det_out <= 1'b0;
        end else if (det_en) begin
            det_out <= det_in;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Offer one word from a source, push its expected result once granted, then withdraw.
    task automatic send(input logic id, input logic [7:0] d, input logic [3:0] c);
        logic got;
        res_t e;
        if (id) begin s1_valid = 1'b1; s1_data = d; end
        else    begin s0_valid = 1'b1; s0_data = d; end
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge sys_clk);
            if (id ? s1_ready : s0_ready) got = 1'b1;
        end
        if (!got) begin
            chk("grant_timeout", 32'(got), 1);
        end else begin
            e.id = id; e.mask = d; e.cnt = c;
            q.push_back(e);
        end
        @(posedge sys_clk);
        #1;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge sys_clk);
        @(negedge sys_clk);
        chk("sb_pending", q.size(), 0);
        tick();
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
    endtask

    initial begin
        logic [7:0] seq;
        int         lat;
        int         gid[4];
        int         gcyc[4];
        int         ng;
        int         seen_valid;
        res_t       e;

        n_cmp = 0; n_err = 0;
        sys_rst = 1'b1;
        s0_valid = 1'b0; s1_valid = 1'b0;
        s0_data = '0; s1_data = '0;
        m_ready = 1'b1;

        // Scoreboard monitor: compare every accepted result against the head of the queue.
        fork
            forever begin
                @(negedge sys_clk);
                if (!sys_rst && m_valid && m_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_result", 32'(m_valid), 0);
                    end else begin
                        e = q.pop_front();
                        chk("m_id", 32'(m_id), 32'(e.id));
                        chk("m_mask", 32'(m_mask), 32'(e.mask));
                        chk("m_count", 32'(m_count), 32'(e.cnt));
                    end
                end
            end
        join_none

        // Reset state.
        tick();
        @(negedge sys_clk);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_det_en", 32'(det_en), 0);
        chk("rst_det_in", 32'(det_in), 0);
        chk("rst_det_clr", 32'(det_clr), 0);
        chk("rst_m_mask", 32'(m_mask), 0);
        chk("rst_m_count", 32'(m_count), 0);
        chk("rst_m_id", 32'(m_id), 0);
        tick();
        sys_rst = 1'b0;
        tick();

        // Single word 0x56: latency, bit order, clear strobe.
        s0_valid = 1'b1; s0_data = 8'b01010110;
        @(negedge sys_clk);
        chk("t1_s0_ready", 32'(s0_ready), 1);
        chk("t1_s1_ready", 32'(s1_ready), 0);
        e.id = 1'b0; e.mask = 8'h56; e.cnt = 4'd4;
        q.push_back(e);
        @(posedge sys_clk);
        #1;
        s0_valid = 1'b0;
        seq = '0; lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge sys_clk);
            if (k >= 1 + OFF && k <= 8 + OFF) seq = {seq[6:0], det_in};
            if (k == 1) begin
                chk("t1_det_clr_c1", 32'(det_clr), OFF);
                chk("t1_det_en_c1", 32'(det_en), 1 - OFF);
            end
            if (k == 2) chk("t1_det_clr_c2", 32'(det_clr), 0);
            if (k == 9 + OFF) begin
                chk("t1_drain_en", 32'(det_en), 1);
                chk("t1_drain_in", 32'(det_in), 0);
            end
            if (m_valid && lat == 0) lat = k;
        end
        chk("t1_det_in_seq", 32'(seq), 32'h56);
        chk("t1_latency", lat, 10 + OFF);
        wait_done();

        // Both sources held valid: alternating grants, fixed throughput.
        do_reset();
        s0_valid = 1'b1; s0_data = 8'hA5;
        s1_valid = 1'b1; s1_data = 8'h3C;
        ng = 0;
        for (int c = 0; c < 200 && ng < 4; c++) begin
            @(negedge sys_clk);
            if (s0_valid && s0_ready) begin
                e.id = 1'b0; e.mask = 8'hA5; e.cnt = 4'd4;
                q.push_back(e); gid[ng] = 0; gcyc[ng] = c; ng++;
            end else if (s1_valid && s1_ready) begin
                e.id = 1'b1; e.mask = 8'h3C; e.cnt = 4'd4;
                q.push_back(e); gid[ng] = 1; gcyc[ng] = c; ng++;
            end
        end
        @(posedge sys_clk);
        #1;
        s0_valid = 1'b0; s1_valid = 1'b0;
        chk("t2_grants", ng, 4);
        if (ng == 4) begin
            chk("t2_gid0", gid[0], 0);
            chk("t2_gid1", gid[1], 1);
            chk("t2_gid2", gid[2], 0);
            chk("t2_gid3", gid[3], 1);
            chk("t2_period", gcyc[1] - gcyc[0], 11 + OFF);
        end
        wait_done();

        // Consumer stall in DONE.
        m_ready = 1'b0;
        send(1'b0, 8'hC3, 4'd4);
        seen_valid = 0;
        for (int i = 0; i < 30 && seen_valid == 0; i++) begin
            @(negedge sys_clk);
            if (m_valid) seen_valid = 1;
        end
        chk("t3_valid_arrives", seen_valid, 1);
        @(posedge sys_clk);
        #1;
        s0_valid = 1'b1; s0_data = 8'h11;
        s1_valid = 1'b1; s1_data = 8'h22;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            chk("t3_hold_valid", 32'(m_valid), 1);
            chk("t3_hold_mask", 32'(m_mask), 32'hC3);
            chk("t3_hold_count", 32'(m_count), 4);
            chk("t3_s0_ready", 32'(s0_ready), 0);
            chk("t3_s1_ready", 32'(s1_ready), 0);
        end
        @(posedge sys_clk);
        #1;
        s0_valid = 1'b0; s1_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        chk("t3_released", 32'(m_valid), 0);
        chk("t3_sb_empty", q.size(), 0);
        tick();

        // Reset while the 4th bit is shifting aborts the word.
        s0_valid = 1'b1; s0_data = 8'hAA;
        @(negedge sys_clk);
        chk("t4_s0_ready", 32'(s0_ready), 1);
        @(posedge sys_clk);
        #1;
        s0_valid = 1'b0;
        tick();
        tick();
        tick();
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("t4_det_en", 32'(det_en), 0);
        chk("t4_m_valid", 32'(m_valid), 0);
        seen_valid = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge sys_clk);
            if (m_valid) seen_valid = 1;
        end
        chk("t4_no_result", seen_valid, 0);
        tick();
        send(1'b0, 8'h0F, 4'd4);
        wait_done();

        // Boundary words.
        send(1'b1, 8'hFF, 4'd8);
        wait_done();
        send(1'b0, 8'h00, 4'd0);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fsm_seq_sched.md
# fsm_seq_sched

Two-requester scheduler that shares one serial sequence-detector datapath (the `fsm*` detector family) between two parallel byte sources. It round-robin arbitrates between the sources and shifts the granted word into the detector MSB-first, one bit per cycle. It captures the detector's per-bit output and returns a hit mask and hit count tagged with the source ID. It sits between producer logic and a clock-enabled wrapper around the detector.

## Interface
- `W`, 8: word width shifted per request; must be ≥ 2.
- `DET_LAT`, 1: cycles from a bit on `det_in` (with `det_en`) to its response on `det_out`; must be ≥ 1.

- `sys_clk`  in  1  single clock, rising-edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `s0_valid` / `s1_valid`  in  1  source word available.
- `s0_data` / `s1_data`  in  W  source word.
- `s0_ready` / `s1_ready`  out  1  grant; a transfer occurs when `sN_valid && sN_ready`.
- `det_en`  out  1  detector clock enable.
- `det_in`  out  1  serial bit to the detector.
- `det_clr`  out  1  detector state clear; present only with the macro, otherwise tied 0.
- `det_out`  in  1  detector output.
- `m_valid`  out  1  result available.
- `m_ready`  in  1  result consumer ready.
- `m_id`  out  1  source of the result: 0 or 1.
- `m_mask`  out  W  `m_mask[i]` is the `det_out` sample for data bit i.
- `m_count`  out  $clog2(W+1)  popcount of `m_mask`.

## Operation
- States:
  - `IDLE`: wait for a request.
  - `CLR`: macro builds only.
  - `SHIFT`: W cycles.
  - `DRAIN`: DET_LAT cycles.
  - `DONE`: hold the result until accepted.
- `IDLE` behaviour:
  - `sN_ready` is combinational: high only in `IDLE`, for the granted source.
  - Grant rule: if exactly one source is valid, grant it. If both are valid, grant the source not served last.
  - The last-served pointer resets to 1, so source 0 wins the first tie.
- On transfer:
  - Latch the data into the shift register and the ID into `m_id`.
  - Update the last-served pointer.
  - Clear the mask and count.
  - Go to `SHIFT`, or to `CLR` with the macro.
- `SHIFT`:
  - `det_en` = 1; `det_in` = shift register MSB; shift left each cycle.
  - A down-counter from W-1 exits to `DRAIN` when it reaches 0.
- `DRAIN`:
  - `det_en` = 1, `det_in` = 0.
  - Counts DET_LAT cycles, then goes to `DONE`.
- Capture:
  - A DET_LAT-deep valid pipeline tags only the SHIFT bits.
  - A tagged `det_out` is shifted into the mask LSB, and the count increments if it is 1.
  - Drain-bit responses are never captured.
- `DONE`:
  - `m_valid` = 1 with `m_id`, `m_mask`, `m_count` stable.
  - On `m_ready`, go to `IDLE`.
  - No source is granted while in `DONE`.
- Count width:
  - Never wraps: the maximum value is W.
  - W = 8 gives 4 bits.
- Outside `SHIFT` and `DRAIN`, `det_en` = 0 and `det_in` = 0.

## Timing
- Reset values, applied on the first rising edge with `sys_rst` high, from any state:
  - state `IDLE`;
  - `m_valid`, `det_en`, `det_in`, `det_clr` = 0;
  - `m_mask`, `m_count`, `m_id` = 0;
  - pointer = 1.
- Reset mid-operation aborts the word; no result is emitted.
- Transfer at edge 0, no macro:
  - `SHIFT` drives bits in cycles 1..W.
  - `DRAIN` runs in cycles W+1..W+DET_LAT.
  - `m_valid` rises in cycle W+DET_LAT+1. For defaults, cycle 10 after accept.
- `m_valid` and `m_ready` both high at an edge: the next cycle is `IDLE`. A new grant appears combinationally in that `IDLE` cycle, so there is one dead cycle between words.
- Throughput for defaults: 1 word per W+DET_LAT+2 cycles.
- `sN_valid` may drop without a transfer; no state is affected.

## Configuration
- `FSM_SEQ_SCHED_CLR_EN` defined:
  - A `CLR` state is inserted after each transfer; for one cycle, `det_clr` = 1, `det_en` = 0, `det_in` = 0.
  - The detector starts every word from its reset state.
  - Latency increases by 1: `m_valid` at cycle W+DET_LAT+2.
- Not defined:
  - No `CLR` state; `det_clr` is constant 0.
  - Detector state carries across words (continuous-stream semantics).

## Test plan
- Echo detector model (`det_out` = `det_in` registered when `det_en`, DET_LAT = 1); s0 sends 8'b01010110 → `m_valid` at cycle 10 after accept, `m_mask` = 8'b01010110, `m_count` = 4, `m_id` = 0, `det_in` sequence 0,1,0,1,0,1,1,0.
- s0 and s1 held valid (0xA5, 0x3C) → grants in order 0,1,0,1; results 0xA5/count 4/id 0, then 0x3C/count 4/id 1.
- Hold `m_ready` low for 5 cycles in `DONE` → `m_valid` stays high, outputs stable, both `sN_ready` stay 0; word accepted on the cycle `m_ready` rises.
- Assert `sys_rst` while the 4th bit is shifting → next cycle `IDLE`, `det_en` = 0, no `m_valid`; the following request 0x0F completes normally with count 4.
- Boundary values: data 0xFF gives `m_count` = 8; data 0x00 gives `m_count` = 0, `m_mask` = 0x00.
- With `FSM_SEQ_SCHED_CLR_EN` defined: `det_clr` is high exactly one cycle (cycle 1 after accept), and `m_valid` arrives at cycle 11.
